// File: rtl/button_conditioner_pkg.sv
// Shared constants for the five-button conditioner: button indices,
// press priority order and the auto-repeat state encoding.
package button_conditioner_pkg;
  localparam int NUM_BTN = 5;
  localparam int ENTER = 4;
  localparam int LEFT  = 3;
  localparam int RIGHT = 2;
  localparam int UP    = 1;
  localparam int DOWN  = 0;

  // Lowest priority first; a later entry overrides an earlier one.
  localparam logic [NUM_BTN-1:0][2:0] PRIO_LO2HI =
    {3'(ENTER), 3'(LEFT), 3'(RIGHT), 3'(UP), 3'(DOWN)};

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HELD_DELAY,
    RPT_HELD_REPEAT
  } rpt_state_e;

  function automatic logic [NUM_BTN-1:0] arbitrate(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] grant;
    grant = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (req[PRIO_LO2HI[i]]) begin
        grant = '0;
        grant[PRIO_LO2HI[i]] = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// One button: 2-flop synchronizer, stable-run debounce counter and
// rising-edge detect of the debounced level.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_d;
endmodule

// File: rtl/button_conditioner.sv
// Five-button conditioner: debounced levels, prioritized single-cycle press
// pulses; up/down auto-repeat compiled in when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_raw,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       left_raw,
  input  logic       right_raw,
  output logic       enter,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [4:0] btn_state,
  output logic       any_press
);
  logic [NUM_BTN-1:0] raw, level, rise, rpt, req, pulse_q, state_q, pulse;

  assign raw = {enter_raw, left_raw, right_raw, up_raw, down_raw};

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("button_conditioner: parameter out of range");
  end

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_cell
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[b]),
      .level (level[b]),
      .rise  (rise[b])
    );
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_rpt
    if (b == UP || b == DOWN) begin : g_fsm
      rpt_state_e    st, st_n;
      logic [RW-1:0] cnt, cnt_n;
      logic          fire;

      always_ff @(posedge clk) begin
        if (reset) begin
          st  <= RPT_IDLE;
          cnt <= '0;
        end else begin
          st  <= st_n;
          cnt <= cnt_n;
        end
      end

      // Keyed off the unarbitrated rise so a discarded press still arms timing.
      always_comb begin
        st_n  = st;
        cnt_n = cnt;
        fire  = 1'b0;
        case (st)
          RPT_IDLE: begin
            if (rise[b]) begin
              st_n  = RPT_HELD_DELAY;
              cnt_n = '0;
            end
          end
          RPT_HELD_DELAY, RPT_HELD_REPEAT: begin
            if (!level[b]) begin
              st_n  = RPT_IDLE;
              cnt_n = '0;
            end else if (cnt == ((st == RPT_HELD_DELAY) ? DELAY_LAST : RATE_LAST)) begin
              fire  = 1'b1;
              st_n  = RPT_HELD_REPEAT;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          default: begin
            st_n  = RPT_IDLE;
            cnt_n = '0;
          end
        endcase
      end

      assign rpt[b] = fire;
    end else begin : g_none
      assign rpt[b] = 1'b0;
    end
  end
`else
  assign rpt = '0;
`endif

  assign req = rise | rpt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_q <= '0;
      state_q <= '0;
    end else begin
      pulse_q <= arbitrate(req);
      state_q <= level;
    end
  end

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign pulse     = pulse_q & {NUM_BTN{~reset}};
  assign btn_state = state_q & {NUM_BTN{~reset}};
  assign enter     = pulse[ENTER];
  assign left      = pulse[LEFT];
  assign right     = pulse[RIGHT];
  assign up        = pulse[UP];
  assign down      = pulse[DOWN];
  assign any_press = |pulse;
endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a cycle reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enter_raw = 0, up_raw = 0, down_raw = 0, left_raw = 0, right_raw = 0;
  logic enter, up, down, left, right, any_press;
  logic [4:0] btn_state;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset(reset),
    .enter_raw(enter_raw), .up_raw(up_raw), .down_raw(down_raw),
    .left_raw(left_raw), .right_raw(right_raw),
    .enter(enter), .up(up), .down(down), .left(left), .right(right),
    .btn_state(btn_state), .any_press(any_press)
  );

  logic [4:0] pulses_act;
  assign pulses_act = {enter, left, right, up, down};

  typedef struct packed { logic [4:0] st; logic [4:0] p; } exp_t;
  typedef struct { int c; logic [4:0] p; } ev_t;
  exp_t exp_q[$];
  ev_t  log_q[$];
  int   ec[$];
  bit   logging = 0;
  int   t0 = 0, cyc = 0, errors = 0, checks = 0;

  // Reference model state, as seen during the current cycle.
  logic [4:0] ms1 = 0, ms2 = 0, mlvl = 0, mlvlp = 0, mreg = 0, mbtn = 0;
  int run[5];
  int press_at[5];

  task automatic model_step(input logic [4:0] r, input logic rs);
    logic [4:0] req, rise;
    if (rs) begin
      ms1 = 0; ms2 = 0; mlvl = 0; mlvlp = 0; mreg = 0; mbtn = 0;
      for (int b = 0; b < 5; b++) begin run[b] = 0; press_at[b] = -1; end
    end else begin
      rise = mlvl & ~mlvlp;
      req  = rise;
`ifdef BTN_AUTOREPEAT_EN
      for (int b = 0; b < 2; b++) begin
        int a;
        a = cyc - press_at[b];
        if (press_at[b] >= 0 && mlvl[b] && a >= RD && (a - RD) % RR == 0) req[b] = 1'b1;
        if (rise[b]) press_at[b] = cyc;
        else if (!mlvl[b]) press_at[b] = -1;
      end
`endif
      if (req[4])      mreg = 5'b10000;
      else if (req[3]) mreg = 5'b01000;
      else if (req[2]) mreg = 5'b00100;
      else if (req[1]) mreg = 5'b00010;
      else if (req[0]) mreg = 5'b00001;
      else             mreg = 5'b00000;
      mbtn  = mlvl;
      mlvlp = mlvl;
      // Level flips once D consecutive synchronized samples disagree with it.
      for (int b = 0; b < 5; b++) begin
        if (ms2[b] != mlvl[b]) begin
          run[b]++;
          if (run[b] == D) begin mlvl[b] = ~mlvl[b]; run[b] = 0; end
        end else run[b] = 0;
      end
      ms2 = ms1;
      ms1 = r;
    end
  endtask

  task automatic tick(input logic [4:0] r, input logic rs);
    @(posedge clk); #1;
    {enter_raw, left_raw, right_raw, up_raw, down_raw} = r;
    reset = rs;
    cyc++;
    exp_q.push_back({mbtn & {5{~rs}}, mreg & {5{~rs}}});
    model_step(r, rs);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({btn_state, pulses_act} !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d: got state=%b pulse=%b, want state=%b pulse=%b",
                 cyc, btn_state, pulses_act, e.st, e.p);
      end
      checks++;
      if (any_press !== (|e.p)) begin
        errors++;
        $display("FAIL any_press cyc=%0d: got %b want %b", cyc, any_press, |e.p);
      end
      if (logging && pulses_act != 5'b0) log_q.push_back('{cyc - t0, pulses_act});
    end
  end

  task automatic scen_begin();
    log_q.delete();
    t0 = cyc + 1;
    logging = 1;
  endtask

  task automatic check_log(input string nm, input logic [4:0] bits);
    logging = 0;
    checks++;
    if (log_q.size() != ec.size()) begin
      errors++;
      $display("FAIL %s pulse count: got %0d want %0d", nm, log_q.size(), ec.size());
    end
    for (int i = 0; i < ec.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].c != ec[i] || log_q[i].p != bits) begin
        errors++;
        $display("FAIL %s pulse %0d: got cycle %0d bits %b, want cycle %0d bits %b",
                 nm, i, log_q[i].c, log_q[i].p, ec[i], bits);
      end
    end
  endtask

  initial begin
    logic [4:0] r;
    int dur[5];
    int rst_left;
    for (int b = 0; b < 5; b++) begin run[b] = 0; press_at[b] = -1; end
    repeat (3) tick(5'b0, 1'b1);
    repeat (3) tick(5'b0, 1'b0);

    // steady up press
    scen_begin();
    repeat (16) tick(5'b00010, 0);
    repeat (25) tick(5'b0, 0);
    ec = '{7};
    check_log("up_single", 5'b00010);

    // short enter glitch
    scen_begin();
    repeat (3) tick(5'b10000, 0);
    repeat (20) tick(5'b0, 0);
    ec = {};
    check_log("enter_glitch", 5'b10000);

    // down held 60 cycles
    scen_begin();
    repeat (60) tick(5'b00001, 0);
    repeat (30) tick(5'b0, 0);
`ifdef BTN_AUTOREPEAT_EN
    ec = '{7, 27, 35, 43, 51, 59};
`else
    ec = '{7};
`endif
    check_log("down_repeat", 5'b00001);

    // enter and up together
    scen_begin();
    repeat (15) tick(5'b10010, 0);
    repeat (25) tick(5'b0, 0);
    ec = '{7};
    check_log("enter_up_prio", 5'b10000);

    // left held through a 2-cycle reset at cycle 5
    scen_begin();
    repeat (5) tick(5'b01000, 0);
    repeat (2) tick(5'b01000, 1);
    repeat (20) tick(5'b01000, 0);
    repeat (20) tick(5'b0, 0);
    ec = '{14};
    check_log("left_reset", 5'b01000);

    // randomized presses, glitches and occasional resets
    r = 5'b0;
    rst_left = 0;
    for (int b = 0; b < 5; b++) dur[b] = $urandom_range(1, 30);
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < 5; b++) begin
        if (dur[b] == 0) begin
          r[b] = ~r[b];
          dur[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 70);
        end else dur[b]--;
      end
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      tick(r, rst_left > 0);
      if (rst_left > 0) rst_left--;
    end

    repeat (3) tick(5'b0, 0);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
